// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage payload widths, bubble constants and pack/unpack helpers
package pipe_pkg;
    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int DATA_W  = 16;
    localparam int CW_W    = 8;
    localparam int K_W     = 3;
    localparam int DEST_W  = 3;
    localparam int IF_ID_W = PC_W + INSTR_W;
    localparam int M2W_W   = PC_W + INSTR_W + DATA_W + CW_W + K_W + DEST_W;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [DATA_W-1:0]  data;
        logic [CW_W-1:0]    cw;
        logic [K_W-1:0]     k;
        logic [DEST_W-1:0]  dest;
    } m2w_t;

    localparam logic [IF_ID_W-1:0] NOP_IF_ID = '0;
    localparam logic [M2W_W-1:0]   NOP_M2W   = '0;

    function automatic logic [IF_ID_W-1:0] pack_if_id(input if_id_t s);
        return s;
    endfunction

    function automatic if_id_t unpack_if_id(input logic [IF_ID_W-1:0] p);
        return if_id_t'(p);
    endfunction

    function automatic logic [M2W_W-1:0] pack_m2w(input m2w_t s);
        return s;
    endfunction

    function automatic m2w_t unpack_m2w(input logic [M2W_W-1:0] p);
        return m2w_t'(p);
    endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional skid entry, flush and stall counter
module pipe_stage_reg #(
    parameter int                DATA_W    = pipe_pkg::M2W_W,
    parameter bit                SKID      = 1'b1,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic up_fire;
    logic dn_fire;
    logic skid_valid;

    assign up_fire = up_valid & up_ready;
    assign dn_fire = dn_valid & dn_ready;
    assign occ     = 2'(dn_valid) + 2'(skid_valid);

    generate
        if (SKID) begin : g_skid
            logic [DATA_W-1:0] skid_data;
            // ready depends only on the skid flop, so dn_ready never reaches up_ready
            assign up_ready = ~skid_valid;
            always_ff @(posedge clk) begin
                if (clr || flush) begin
                    dn_valid   <= 1'b0;
                    dn_data    <= NOP_VALUE;
                    skid_valid <= 1'b0;
                    skid_data  <= NOP_VALUE;
                end else if (dn_fire || !dn_valid) begin
                    if (skid_valid) begin
                        dn_valid   <= 1'b1;
                        dn_data    <= skid_data;
                        skid_valid <= 1'b0;
                        skid_data  <= NOP_VALUE;
                    end else begin
                        dn_valid <= up_fire;
                        dn_data  <= up_fire ? up_data : NOP_VALUE;
                    end
                end else if (up_fire) begin
                    skid_valid <= 1'b1;
                    skid_data  <= up_data;
                end
            end
        end else begin : g_single
            assign skid_valid = 1'b0;
            assign up_ready   = ~dn_valid | dn_ready;
            always_ff @(posedge clk) begin
                if (clr || flush) begin
                    dn_valid <= 1'b0;
                    dn_data  <= NOP_VALUE;
                end else if (up_fire) begin
                    dn_valid <= 1'b1;
                    dn_data  <= up_data;
                end else if (dn_fire) begin
                    dn_valid <= 1'b0;
                    dn_data  <= NOP_VALUE;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr)
            stall_cnt <= '0;
        else if (dn_valid && !dn_ready && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: checks SKID=1 and SKID=0 stages against a FIFO-queue model plus literal expectations
module tb_pipe_stage_reg;
    localparam int W    = pipe_pkg::M2W_W;
    localparam int CMAX = 65535;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         flush = 1'b0;
    logic         up_valid = 1'b0;
    logic         dn_ready = 1'b0;
    logic [W-1:0] up_data = '0;

    logic         ur1, dv1, ur0, dv0;
    logic [W-1:0] dd1, dd0;
    logic [1:0]   occ1, occ0;
    logic [15:0]  sc1, sc0;

    int compared = 0;
    int mismatched = 0;

    pipe_stage_reg #(.SKID(1'b1)) u_dut (
        .clk(clk), .clr(clr), .flush(flush),
        .up_valid(up_valid), .up_ready(ur1), .up_data(up_data),
        .dn_valid(dv1), .dn_ready(dn_ready), .dn_data(dd1),
        .occ(occ1), .stall_cnt(sc1)
    );

    pipe_stage_reg #(.SKID(1'b0)) u_dut0 (
        .clk(clk), .clr(clr), .flush(flush),
        .up_valid(up_valid), .up_ready(ur0), .up_data(up_data),
        .dn_valid(dv0), .dn_ready(dn_ready), .dn_data(dd0),
        .occ(occ0), .stall_cnt(sc0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each stage is a FIFO of capacity 2 (skid) or 1 (single)
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];
    int  c1 = 0, c0 = 0;
    bit  started = 0;
    bit  mr1, mr0;

    always @(posedge clk) begin
        mr1 = q1.size() < 2;
        mr0 = q0.size() == 0 || dn_ready;
        if (clr) begin
            q1.delete(); q0.delete(); c1 = 0; c0 = 0; started = 1;
        end else begin
            if (q1.size() > 0 && !dn_ready && c1 != CMAX) c1++;
            if (q0.size() > 0 && !dn_ready && c0 != CMAX) c0++;
            if (flush) begin
                q1.delete(); q0.delete();
            end else begin
                if (q1.size() > 0 && dn_ready) void'(q1.pop_front());
                if (up_valid && mr1) q1.push_back(up_data);
                if (q0.size() > 0 && dn_ready) void'(q0.pop_front());
                if (up_valid && mr0) q0.push_back(up_data);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m1_dn_valid", 64'(dv1), 64'(q1.size() > 0));
            chk("m1_dn_data", 64'(dd1), q1.size() > 0 ? 64'(q1[0]) : 64'(0));
            chk("m1_up_ready", 64'(ur1), 64'(q1.size() < 2));
            chk("m1_occ", 64'(occ1), 64'(q1.size()));
            chk("m1_stall", 64'(sc1), 64'(c1));
            chk("m0_dn_valid", 64'(dv0), 64'(q0.size() > 0));
            chk("m0_dn_data", 64'(dd0), q0.size() > 0 ? 64'(q0[0]) : 64'(0));
            chk("m0_up_ready", 64'(ur0), 64'(q0.size() == 0 || dn_ready));
            chk("m0_occ", 64'(occ0), 64'(q0.size()));
            chk("m0_stall", 64'(sc0), 64'(c0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pl(input logic [15:0] pc, input logic [2:0] dest);
        pipe_pkg::m2w_t s;
        s = '{pc: pc, instr: 16'hA5A5, data: pc ^ 16'hFFFF, cw: 8'h3C, k: 3'd5, dest: dest};
        return pipe_pkg::pack_m2w(s);
    endfunction

    logic [W-1:0] s0, s1, s2, a, b, c, d, e, f;

    initial begin
        s0 = pl(16'h1234, 3'd1); s1 = pl(16'h1235, 3'd2); s2 = pl(16'h1236, 3'd3);
        a = pl(16'h0A00, 3'd4); b = pl(16'h0B00, 3'd5); c = pl(16'h0C00, 3'd6);
        d = pl(16'h0D00, 3'd7); e = pl(16'h0E00, 3'd0); f = pl(16'h0F00, 3'd1);

        clr = 1'b1; tick(); clr = 1'b0; tick();
        chk("rst_dn_valid", 64'(dv1), 64'd0);
        chk("rst_dn_data", 64'(dd1), 64'd0);
        chk("rst_up_ready", 64'(ur1), 64'd1);
        chk("rst_occ", 64'(occ1), 64'd0);
        chk("rst_stall", 64'(sc1), 64'd0);

        dn_ready = 1'b1; up_valid = 1'b1;
        up_data = s0; tick();
        chk("str0_m1", 64'(dd1), 64'(s0));
        up_data = s1; tick();
        chk("str1_m1", 64'(dd1), 64'(s1));
        chk("str1_m0", 64'(dd0), 64'(s1));
        up_data = s2; tick();
        chk("str2_m1", 64'(dd1), 64'(s2));
        chk("str2_occ1", 64'(occ1), 64'd1);
        chk("str2_occ0", 64'(occ0), 64'd1);
        up_valid = 1'b0; tick();
        chk("drain_occ", 64'(occ1), 64'd0);

        dn_ready = 1'b0; up_valid = 1'b1;
        up_data = a; tick();
        up_data = b; tick();
        up_data = c; tick(); tick();
        chk("stall_occ1", 64'(occ1), 64'd2);
        chk("stall_ur1", 64'(ur1), 64'd0);
        chk("stall_dd1", 64'(dd1), 64'(a));
        chk("stall_cnt1", 64'(sc1), 64'd3);
        chk("stall_occ0", 64'(occ0), 64'd1);
        chk("stall_ur0", 64'(ur0), 64'd0);
        chk("stall_dd0", 64'(dd0), 64'(a));
        chk("stall_cnt0", 64'(sc0), 64'd3);
        dn_ready = 1'b1; tick();
        chk("rel_b", 64'(dd1), 64'(b));
        chk("rel_ur1", 64'(ur1), 64'd1);
        tick();
        chk("rel_c", 64'(dd1), 64'(c));
        up_valid = 1'b0; tick();

        dn_ready = 1'b0; up_valid = 1'b1;
        up_data = d; tick();
        up_data = e; tick();
        chk("pre_flush_occ", 64'(occ1), 64'd2);
        flush = 1'b1; dn_ready = 1'b1; up_data = f; tick();
        flush = 1'b0; up_valid = 1'b0;
        chk("flush_occ1", 64'(occ1), 64'd0);
        chk("flush_occ0", 64'(occ0), 64'd0);
        chk("flush_dd1", 64'(dd1), 64'd0);
        chk("flush_cnt1", 64'(sc1), 64'd4);
        chk("flush_cnt0", 64'(sc0), 64'd4);

        dn_ready = 1'b0; up_valid = 1'b1;
        up_data = d; tick();
        up_data = e; tick();
        chk("mid_occ1", 64'(occ1), 64'd2);
        clr = 1'b1; tick(); clr = 1'b0; up_valid = 1'b0;
        chk("clr_occ1", 64'(occ1), 64'd0);
        chk("clr_cnt1", 64'(sc1), 64'd0);
        chk("clr_ur1", 64'(ur1), 64'd1);

        up_valid = 1'b1; up_data = a; tick();
        up_valid = 1'b0;
        repeat (65536 + 5) tick();
        chk("sat_cnt1", 64'(sc1), 64'hFFFF);
        chk("sat_cnt0", 64'(sc0), 64'hFFFF);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("sat_clr1", 64'(sc1), 64'd0);
        chk("sat_clr0", 64'(sc0), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register: the generic successor to the fixed-field stage registers between IF/ID/EX/MEM/WB. It carries an opaque payload of configurable width with a valid/ready handshake instead of a bare enable. An optional second skid entry breaks the combinational ready path. It supports squash (flush) separately from reset, exposes its occupancy, and keeps a saturating back-pressure counter for performance debug.

## Interface
Parameters:
- DATA_W, 62, payload width; default equals pc 16 + instr 16 + data 16 + cw 8 + k 3 + dest 3.
- SKID, 1, 1 = two-entry skid buffer with registered up_ready; 0 = single entry with combinational up_ready.
- NOP_VALUE, {DATA_W{1'b0}}, payload driven whenever an entry is empty (bubble).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous squash of all held entries.
- up_valid  in  1  upstream payload valid.
- up_ready  out  1  stage accepts a payload this cycle.
- up_data  in  DATA_W  upstream payload.
- dn_valid  out  1  output payload valid.
- dn_ready  in  1  downstream accepts.
- dn_data  out  DATA_W  output payload; equals NOP_VALUE when dn_valid=0.
- occ  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  saturating count of cycles with dn_valid=1 and dn_ready=0.

## Operation
- up_fire = up_valid & up_ready; dn_fire = dn_valid & dn_ready.
- State: main entry (dn_valid, dn_data). With SKID=1, also a skid entry (skid_valid, skid_data).
- SKID=0: up_ready = ~dn_valid | dn_ready. On an edge:
  - if up_fire, main <= up_data with valid=1;
  - else if dn_fire, main <= NOP_VALUE with valid=0;
  - else hold.
- SKID=1: up_ready = ~skid_valid, driven from a flop. On an edge:
  - if dn_fire or ~dn_valid:
    - skid_valid: main <= skid, skid <= NOP_VALUE/0;
    - else up_fire: main <= up_data, valid=1;
    - else: main <= NOP_VALUE, valid=0.
  - else (main stalled) and up_fire: skid <= up_data, skid_valid=1.
- Payload order is strictly FIFO. No payload is duplicated or dropped except by flush or clr.
- flush: next edge sets all entries to NOP_VALUE, valid=0. Any up_fire in that cycle is discarded; the upstream must treat it as squashed. stall_cnt is unaffected.
- clr: same effect on entries as flush, and also sets stall_cnt=0. clr has priority over flush. flush has priority over the handshake.
- stall_cnt increments on each cycle with dn_valid & ~dn_ready, saturates at all-ones, and is cleared only by clr.
- occ = dn_valid + skid_valid.

## Timing
- Reset values (after clr edge): dn_valid=0, dn_data=NOP_VALUE, skid_valid=0, occ=0, stall_cnt=0, up_ready=1.
- Latency: up_fire at edge N puts the payload on dn_data/dn_valid after edge N when the main entry is free.
- Full throughput: one payload per cycle while dn_ready=1.
- SKID=1: no combinational path from dn_ready to up_ready; up_ready falls the cycle after a stall captures into skid.
- SKID=0: combinational dn_ready -> up_ready path, permitted by design.
- Simultaneous dn_fire and up_fire with main full and skid empty: main replaced by up_data in one edge; occ stays 1.
- Simultaneous flush and up_valid: nothing captured; occ=0 next cycle.
- clr mid-stall (occ=2): both entries dropped; stall_cnt=0.

## Structure
- Shared package pipe_pkg: stage payload width constants (PC_W=16, INSTR_W=16, DATA_W=16, CW_W=8, K_W=3, DEST_W=3), the NOP_M2W payload constant, and pack/unpack functions for each stage's payload.
- Single module. No sub-module needed; the skid entry is a generate-if on SKID inside pipe_stage_reg.

## Test plan
- clr then idle -> dn_valid=0, dn_data=NOP_VALUE, up_ready=1, occ=0, stall_cnt=0.
- Stream 0x1234..., 0x1235..., 0x1236... with dn_ready=1 -> identical sequence out one cycle later, one per cycle, occ=1.
- SKID=1: hold dn_ready=0 for 3 cycles while up_valid=1 -> payloads A and B held (occ=2), up_ready=0, stall_cnt=3. Release -> A, then B, then C, in order with no loss.
- SKID=0, same stimulus -> only A held, up_ready=0 combinationally, stall_cnt=3.
- flush with occ=2 and up_valid=1 -> next cycle occ=0, dn_data=NOP_VALUE, stall_cnt unchanged.
- Force stall for 2^CNT_W+5 cycles -> stall_cnt saturates at 0xFFFF; clr -> 0.
